// File: rtl/isa_host_cycle_initiator.sv
// ----------------------------------------------------------------------------
// isa_host_cycle_initiator
//
// Host-side ISA bus initiator. Takes one queued command at a time (memory or
// IO, read or write, 8 or 16 bit) and runs it as a complete ISA cycle:
// free-running ISA_CLK, BALE, SBHE and address, command strobes, wait-state
// handling, and read-data return. A 16-bit request that the target cannot
// take as a single 16-bit cycle is done as two 8-bit cycles.
//
// Ports
//   FPGACLK, RESET        sole clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_type              00 mem rd, 01 mem wr, 10 IO rd, 11 IO wr
//   cmd_addr, cmd_wdata   byte address and write data ([7:0] = byte at addr)
//   cmd_16                request a 16-bit transfer
//   rsp_valid             one-cycle pulse when the command has finished
//   rsp_rdata             read data ([7:0] = byte at addr)
//   rsp_err, rsp_split    IO_RDY timeout seen / request done as two 8-bit cycles
//   ISA_CLK, BALE, SBHE   bus clock, address latch enable, byte-high enable (low)
//   addressBus            20-bit ISA address
//   data_out, data_oe     write data and pad-driver enable; data_in bus data
//   MEMR..IOW             active-low command strobes
//   MEMCS16, IOCS16, NOWS active-low target responses; IO_RDY low = wait
// ----------------------------------------------------------------------------
module isa_host_cycle_initiator #(
    parameter int ISA_HALF    = 4,
    parameter int CMD_CLKS_16 = 2,
    parameter int CMD_CLKS_8  = 5,
    parameter int RDY_TIMEOUT = 16
) (
    input  logic        FPGACLK,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic        cmd_16,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_split,
    output logic        ISA_CLK,
    output logic        BALE,
    output logic        SBHE,
    output logic [19:0] addressBus,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    output logic        MEMR,
    output logic        MEMW,
    output logic        SMEMR,
    output logic        SMEMW,
    output logic        IOR,
    output logic        IOW,
    input  logic        MEMCS16,
    input  logic        IOCS16,
    input  logic        NOWS,
    input  logic        IO_RDY
);

    localparam int              HW        = (ISA_HALF > 2) ? $clog2(ISA_HALF) : 1;
    localparam logic [HW-1:0]   HALF_LAST = HW'(ISA_HALF - 1);
    localparam logic [7:0]      N16       = 8'(CMD_CLKS_16);
    localparam logic [7:0]      N8        = 8'(CMD_CLKS_8);
    localparam logic [7:0]      TO_LAST   = 8'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CMD, S_WAIT, S_RECOV} state_t;

    state_t        state, state_nx;
    logic [HW-1:0] half_cnt;
    logic          isa_clk_q;
    logic          tick;

    // latched command
    logic [1:0]    type_q;
    logic [19:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          c16_q;

    logic          pend;        // command accepted, waiting for the next tick
    logic          half2;       // second half of a split transfer
    logic          wide16;      // current cycle runs as a true 16-bit cycle
    logic          split_q;
    logic          err_q;
    logic [7:0]    cmd_cnt;
    logic [7:0]    wait_cnt;
    logic [15:0]   rd_acc;

    logic          cs16_n;
    logic          cmd_last;
    logic          in_cmd_nx;
    logic          to_recov;
    logic [19:0]   addr_inc;
    logic [7:0]    wbyte;
    logic [7:0]    rbyte;
    logic          memr_nx, memw_nx, ior_nx, iow_nx, bale_nx, oe_nx;

    assign ISA_CLK  = isa_clk_q;
    // tick marks the FPGACLK cycle whose closing edge raises ISA_CLK
    assign tick     = (half_cnt == HALF_LAST) && !isa_clk_q;
    assign cs16_n   = type_q[1] ? IOCS16 : MEMCS16;
    assign addr_inc = addr_q + 20'd1;
    // NOWS can only shorten the cycle once the first command clock is over
    assign cmd_last = (cmd_cnt == (wide16 ? N16 : N8)) || (!NOWS && (cmd_cnt >= 8'd2));
    assign to_recov = ((state == S_CMD) || (state == S_WAIT)) && (state_nx == S_RECOV);
    // 8-bit cycles put the selected byte on both lanes
    assign wbyte    = half2 ? wdata_q[15:8] : wdata_q[7:0];
    assign data_out = wide16 ? wdata_q : {wbyte, wbyte};
    assign rbyte    = addressBus[0] ? data_in[15:8] : data_in[7:0];

    always_ff @(posedge FPGACLK or negedge RESET) begin
        if (!RESET) begin
            half_cnt  <= '0;
            isa_clk_q <= 1'b0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt  <= '0;
            isa_clk_q <= !isa_clk_q;
        end else begin
            half_cnt  <= half_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pend && tick) state_nx = S_ADDR;
            S_ADDR:  if (tick) state_nx = S_CMD;
            S_CMD:   if (tick && cmd_last) state_nx = IO_RDY ? S_RECOV : S_WAIT;
            S_WAIT:  if (tick && (IO_RDY || (wait_cnt == TO_LAST))) state_nx = S_RECOV;
            S_RECOV: if (tick) state_nx = (split_q && !half2) ? S_ADDR : S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        in_cmd_nx = (state_nx == S_CMD) || (state_nx == S_WAIT);
        memr_nx   = !(in_cmd_nx && (type_q == 2'b00));
        memw_nx   = !(in_cmd_nx && (type_q == 2'b01));
        ior_nx    = !(in_cmd_nx && (type_q == 2'b10));
        iow_nx    = !(in_cmd_nx && (type_q == 2'b11));
        bale_nx   = (state_nx == S_ADDR);
        // write data stays driven through recovery for hold time
        oe_nx     = type_q[0] && (in_cmd_nx || (state_nx == S_RECOV));
    end

    always_ff @(posedge FPGACLK) begin
        if (cmd_valid && cmd_ready) begin
            type_q  <= cmd_type;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            c16_q   <= cmd_16;
        end
        if ((state == S_IDLE) && (state_nx == S_ADDR)) begin
            rd_acc <= 16'h0000;
        end else if (to_recov && !type_q[0]) begin
            // data_in is taken in the cycle just before the strobe rises
            if (wide16)     rd_acc        <= data_in;
            else if (half2) rd_acc[15:8]  <= rbyte;
            else            rd_acc[7:0]   <= rbyte;
        end
    end

    always_ff @(posedge FPGACLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            pend       <= 1'b0;
            half2      <= 1'b0;
            wide16     <= 1'b0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
            cmd_cnt    <= 8'd0;
            wait_cnt   <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 16'h0000;
            rsp_err    <= 1'b0;
            rsp_split  <= 1'b0;
            addressBus <= 20'h00000;
            SBHE       <= 1'b1;
            BALE       <= 1'b0;
            data_oe    <= 1'b0;
            MEMR       <= 1'b1;
            MEMW       <= 1'b1;
            SMEMR      <= 1'b1;
            SMEMW      <= 1'b1;
            IOR        <= 1'b1;
            IOW        <= 1'b1;
        end else begin
            state     <= state_nx;
            MEMR      <= memr_nx;
            MEMW      <= memw_nx;
            SMEMR     <= memr_nx;
            SMEMW     <= memw_nx;
            IOR       <= ior_nx;
            IOW       <= iow_nx;
            BALE      <= bale_nx;
            data_oe   <= oe_nx;
            rsp_valid <= 1'b0;

            if (cmd_valid && cmd_ready) begin
                cmd_ready <= 1'b0;
                pend      <= 1'b1;
            end
            if (rsp_valid) cmd_ready <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (state_nx == S_ADDR) begin
                        pend       <= 1'b0;
                        half2      <= 1'b0;
                        wide16     <= 1'b0;
                        split_q    <= 1'b0;
                        err_q      <= 1'b0;
                        addressBus <= addr_q;
                        // a 16-bit request at an even address announces itself on SBHE
                        SBHE       <= !(addr_q[0] || c16_q);
                    end
                end
                S_ADDR: begin
                    if (tick) begin
                        cmd_cnt <= 8'd1;
                        if (!half2) begin
                            wide16  <= c16_q && !addr_q[0] && !cs16_n;
                            split_q <= c16_q && !(!addr_q[0] && !cs16_n);
                        end
                    end
                end
                S_CMD: begin
                    if (tick && (state_nx == S_CMD))  cmd_cnt  <= cmd_cnt + 8'd1;
                    if (tick && (state_nx == S_WAIT)) wait_cnt <= 8'd0;
                end
                S_WAIT: begin
                    if (tick && (state_nx == S_WAIT)) wait_cnt <= wait_cnt + 8'd1;
                    if (tick && !IO_RDY && (state_nx == S_RECOV)) err_q <= 1'b1;
                end
                S_RECOV: begin
                    if (tick) begin
                        if (state_nx == S_ADDR) begin
                            half2      <= 1'b1;
                            addressBus <= addr_inc;
                            SBHE       <= !addr_inc[0];
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_rdata  <= rd_acc;
                            rsp_err    <= err_q;
                            rsp_split  <= split_q;
                            SBHE       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
